car_sequence_gen: RTL and testbench

CAR_SEQUENCE_GEN -- requirements
Module: car_sequence_gen

---
 rtl/car_sequence_gen.sv | 132 +++++++++++++
 tb/tb_car_sequence_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/car_sequence_gen.sv
// Emulates a car passing two active-low photo-sensors (outer A, inner B) to
// drive a parking-lot counter, and tracks the emulated lot occupancy.
module car_sequence_gen #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CAPACITY    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_req,
  input  logic       exit_req,
  output logic       sensor_a,
  output logic       sensor_b,
  output logic       busy,
  output logic       done,
  output logic       reject,
  output logic [2:0] occupancy
);

  localparam int unsigned CW = 8;
  localparam int unsigned OW = 3;

  typedef enum logic [1:0] {IDLE, FIRST, BOTH, SECOND} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            dir, dir_d;          // 1 = entering, 0 = leaving
  logic [OW-1:0]   occ_d;
  logic            done_d, reject_d, busy_d;
  logic            sa_d, sb_d;
  logic            phase_end;

  assign phase_end = (cnt == CW'(HOLD_CYCLES - 1));

  // State and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dir       <= 1'b0;
      occupancy <= '0;
      done      <= 1'b0;
      reject    <= 1'b0;
      busy      <= 1'b0;
      sensor_a  <= 1'b1;
      sensor_b  <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      dir       <= dir_d;
      occupancy <= occ_d;
      done      <= done_d;
      reject    <= reject_d;
      busy      <= busy_d;
      sensor_a  <= sa_d;
      sensor_b  <= sb_d;
    end
  end

  // Next state, request arbitration and next output values
  always_comb begin
    state_d  = state;
    cnt_d    = cnt + CW'(1);
    dir_d    = dir;
    occ_d    = occupancy;
    done_d   = 1'b0;
    reject_d = 1'b0;

    case (state)
      IDLE: begin
        cnt_d = '0;
        // Enter wins; a refused enter (lot full) falls through to the exit
        if (enter_req && (occupancy != OW'(CAPACITY))) begin
          state_d = FIRST;
          dir_d   = 1'b1;
        end else if (exit_req && (occupancy != '0)) begin
          state_d = FIRST;
          dir_d   = 1'b0;
        end else if (enter_req || exit_req) begin
          reject_d = 1'b1;
        end
      end
      FIRST: begin
        if (phase_end) begin
          state_d = BOTH;
          cnt_d   = '0;
        end
      end
      BOTH: begin
        if (phase_end) begin
          state_d = SECOND;
          cnt_d   = '0;
        end
      end
      SECOND: begin
        if (phase_end) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          occ_d   = dir ? occupancy + OW'(1) : occupancy - OW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Entering blocks A first, leaving blocks B first
    sa_d = 1'b1;
    sb_d = 1'b1;
    case (state_d)
      FIRST: begin
        sa_d = ~dir_d;
        sb_d = dir_d;
      end
      BOTH: begin
        sa_d = 1'b0;
        sb_d = 1'b0;
      end
      SECOND: begin
        sa_d = dir_d;
        sb_d = ~dir_d;
      end
      default: begin
        sa_d = 1'b1;
        sb_d = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_car_sequence_gen.sv
// Bench for car_sequence_gen: per-cycle comparison against a timeline model
// plus directed sequences with literal expectations.
module tb_car_sequence_gen;

  localparam int H   = 2;
  localparam int CAP = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       sensor_a, sensor_b, busy, done, reject;
  logic [2:0] occupancy;

  int passed = 0;
  int total  = 0;
  bit cmp_en = 1'b0;

  car_sequence_gen #(.HOLD_CYCLES(H), .CAPACITY(CAP)) dut (
    .clk(clk), .reset(reset), .enter_req(enter_req), .exit_req(exit_req),
    .sensor_a(sensor_a), .sensor_b(sensor_b), .busy(busy), .done(done),
    .reject(reject), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Model: a running car is a time index t since acceptance; phase = t / H
  bit m_run = 1'b0;
  int m_t   = 0;
  bit m_dir = 1'b0;
  int m_occ = 0;
  bit m_done = 1'b0;
  bit m_rej  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 1'b0; m_t = 0; m_occ = 0; m_done = 1'b0; m_rej = 1'b0;
    end else begin
      m_done = 1'b0;
      m_rej  = 1'b0;
      if (m_run) begin
        m_t = m_t + 1;
        if (m_t == 3 * H) begin
          m_run  = 1'b0;
          m_done = 1'b1;
          m_occ  = m_occ + (m_dir ? 1 : -1);
        end
      end else if (enter_req && m_occ < CAP) begin
        m_run = 1'b1; m_t = 0; m_dir = 1'b1;
      end else if (exit_req && m_occ > 0) begin
        m_run = 1'b1; m_t = 0; m_dir = 1'b0;
      end else begin
        m_rej = enter_req || exit_req;
      end
    end
  end

  function automatic int exp_ab();
    int ph;
    int enter_tab [3] = '{1, 0, 2};   // (a,b) = 01, 00, 10
    int exit_tab  [3] = '{2, 0, 1};   // (a,b) = 10, 00, 01
    if (!m_run) return 3;
    ph = m_t / H;
    return m_dir ? enter_tab[ph] : exit_tab[ph];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_ab", int'({sensor_a, sensor_b}), exp_ab());
      chk("model_busy", int'(busy), int'(m_run));
      chk("model_done", int'(done), int'(m_done));
      chk("model_reject", int'(reject), int'(m_rej));
      chk("model_occ", int'(occupancy), m_occ);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle request and capture (a,b) from the accept edge onward
  task automatic run_seq(input bit en, input bit ex, output logic [13:0] seq);
    enter_req = en;
    exit_req  = ex;
    step();
    enter_req = 1'b0;
    exit_req  = 1'b0;
    seq = {12'b0, sensor_a, sensor_b};
    for (int i = 0; i < 6; i++) begin
      step();
      seq = {seq[11:0], sensor_a, sensor_b};
    end
  endtask

  logic [13:0] seq;
  int busy_cnt;

  initial begin
    reset = 1'b1;
    step();
    cmp_en = 1'b1;
    step();
    chk("reset_state", int'({sensor_a, sensor_b, busy, done, reject, occupancy}), 8'b1100_0000);
    reset = 1'b0;
    step();

    run_seq(1'b1, 1'b0, seq);
    chk("enter_seq", int'(seq), 14'b01_01_00_00_10_10_11);
    chk("enter_done", int'(done), 1);
    chk("enter_occ", int'(occupancy), 1);
    step();

    run_seq(1'b0, 1'b1, seq);
    chk("exit_seq", int'(seq), 14'b10_10_00_00_01_01_11);
    chk("exit_done", int'(done), 1);
    chk("exit_occ", int'(occupancy), 0);
    step();

    exit_req = 1'b1;
    step();
    exit_req = 1'b0;
    chk("empty_reject", int'(reject), 1);
    chk("empty_idle", int'({sensor_a, sensor_b, busy}), 3'b110);
    step();
    chk("reject_pulse", int'(reject), 0);

    run_seq(1'b1, 1'b1, seq);
    chk("both_enter_wins", int'(seq), 14'b01_01_00_00_10_10_11);
    chk("both_occ", int'(occupancy), 1);
    run_seq(1'b0, 1'b1, seq);

    // Exit request while busy is neither queued nor rejected
    enter_req = 1'b1;
    step();
    enter_req = 1'b0;
    step();
    exit_req = 1'b1;
    step();
    exit_req = 1'b0;
    repeat (4) step();
    chk("busy_ignore_occ", int'(occupancy), 1);
    step();
    chk("busy_not_queued", int'(busy), 0);
    run_seq(1'b0, 1'b1, seq);

    // Held enter: seven back-to-back sequences, then rejects
    enter_req = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 49; i++) begin
      step();
      if (busy) busy_cnt++;
    end
    chk("held_busy_cycles", busy_cnt, 42);
    chk("held_occ_full", int'(occupancy), 7);
    chk("held_last_done", int'(done), 1);
    step();
    chk("full_reject", int'(reject), 1);
    step();
    chk("full_reject_held", int'(reject), 1);

    exit_req = 1'b1;
    step();
    chk("full_exit_ab", int'({sensor_a, sensor_b, busy, reject}), 4'b1010);
    enter_req = 1'b0;
    exit_req  = 1'b0;
    repeat (6) step();
    chk("full_exit_occ", int'(occupancy), 6);
    chk("full_exit_done", int'(done), 1);
    step();

    // Reset in BOTH aborts the sequence asynchronously
    enter_req = 1'b1;
    step();
    enter_req = 1'b0;
    step();
    step();
    chk("pre_reset_both", int'({sensor_a, sensor_b}), 0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", int'({sensor_a, sensor_b, busy, done, reject, occupancy}), 8'b1100_0000);
    step();
    reset = 1'b0;
    repeat (8) step();
    chk("post_reset_occ", int'(occupancy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
